// File: rtl/uart_beacon_tx.sv
// ============================================================================
// uart_beacon_tx
//
// Autonomous UART beacon for board bring-up. After reset it repeats the
// ASCII message "FPGAScope\r\n" on TXD forever. Each repeat ends with a gap
// of GAP_BITS idle bit-times. No other logic talks to this block: a working
// terminal on the host PC shows that the clock, the baud divider and the TX
// pin are all alive.
//
// Parameters:
//   CLKS_PER_BIT  system clock cycles per serial bit (>= 2), default 868
//                 (100 MHz / 115200 baud)
//   GAP_BITS      idle bit-times between message repeats (>= 1), default 16
//
// Ports:
//   clk   input   system clock, all logic on the rising edge
//   rst   input   asynchronous reset, active low
//   TXD   output  serial data, idle high, driven straight from a flop
//
// Optional feature (compile-time macro UART_PARITY_EN):
//   defined    - an even-parity bit follows data bit 7 (11-bit frame)
//   undefined  - plain 8N1 framing (10-bit frame)
// ============================================================================
module uart_beacon_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int GAP_BITS     = 16
) (
    input  logic clk,
    input  logic rst,
    output logic TXD
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_BITS - 1);
    localparam logic [3:0]       LAST_BYTE = 4'd10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        GAP    = 3'd5
    } state_t;

`ifdef UART_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  baud_cnt;
    logic              tick;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_idx_next;
    logic [3:0]        byte_idx;
    logic [3:0]        byte_idx_next;
    logic [GAP_W-1:0]  gap_cnt;
    logic [GAP_W-1:0]  gap_cnt_next;
    logic [7:0]        cur_byte;
    logic              txd_next;

    // Message ROM: "FPGAScope\r\n"
    function automatic logic [7:0] msg_byte(input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = 8'h46;
            4'd1:    b = 8'h50;
            4'd2:    b = 8'h47;
            4'd3:    b = 8'h41;
            4'd4:    b = 8'h53;
            4'd5:    b = 8'h63;
            4'd6:    b = 8'h6F;
            4'd7:    b = 8'h70;
            4'd8:    b = 8'h65;
            4'd9:    b = 8'h0D;
            4'd10:   b = 8'h0A;
            default: b = 8'h46;
        endcase
        return b;
    endfunction

    // One tick per bit-time. Every state change happens on a tick.
    assign tick = (baud_cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Unknown encodings fall back to IDLE.
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = tick ? START : IDLE;
            START:   state_next = tick ? DATA : START;
            DATA: begin
                if (tick && (bit_idx == 3'd7)) begin
                    state_next = AFTER_DATA;
                end else begin
                    state_next = DATA;
                end
            end
`ifdef UART_PARITY_EN
            PARITY:  state_next = tick ? STOP : PARITY;
`endif
            STOP: begin
                if (tick) begin
                    state_next = (byte_idx == LAST_BYTE) ? GAP : START;
                end else begin
                    state_next = STOP;
                end
            end
            GAP: begin
                if (tick && (gap_cnt == GAP_LAST)) begin
                    state_next = START;
                end else begin
                    state_next = GAP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Index updates. The bit index wraps from 7 to 0 by itself, so it is
    // already 0 when the next frame starts. Entering IDLE, which only happens
    // after an illegal encoding, clears all indices so the message restarts.
    always_comb begin
        bit_idx_next  = bit_idx;
        byte_idx_next = byte_idx;
        gap_cnt_next  = gap_cnt;
        if (tick) begin
            case (state)
                DATA: bit_idx_next = bit_idx + 3'd1;
                STOP: byte_idx_next = (byte_idx == LAST_BYTE) ? 4'd0
                                                              : byte_idx + 4'd1;
                GAP:  gap_cnt_next = (gap_cnt == GAP_LAST) ? '0
                                                           : gap_cnt + GAP_W'(1);
                default: ;
            endcase
        end
        if (state_next == IDLE) begin
            bit_idx_next  = 3'd0;
            byte_idx_next = 4'd0;
            gap_cnt_next  = '0;
        end
    end

    // Output logic. TXD is computed from the next state and next indices.
    // It is then registered on the same edge as the state change, so the
    // line changes exactly at bit boundaries.
    always_comb begin
        cur_byte = msg_byte(byte_idx_next);
        txd_next = 1'b1;
        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = cur_byte[bit_idx_next];
`ifdef UART_PARITY_EN
            PARITY:  txd_next = ^cur_byte;
`endif
            default: txd_next = 1'b1;
        endcase
    end

    // Baud counter. It restarts on every state entry, so the first bit after
    // reset or after recovery is a full bit-time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt <= '0;
        end else if (tick || (state_next != state)) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
        end
    end

    // Index registers and the TXD output flop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_idx  <= 3'd0;
            byte_idx <= 4'd0;
            gap_cnt  <= '0;
            TXD      <= 1'b1;
        end else begin
            bit_idx  <= bit_idx_next;
            byte_idx <= byte_idx_next;
            gap_cnt  <= gap_cnt_next;
            TXD      <= txd_next;
        end
    end

endmodule

// File: tb/tb_uart_beacon_tx.sv
// ============================================================================
// tb_uart_beacon_tx
//
// Bench for the UART beacon. A small UART receiver decodes TXD. It takes
// each decoded frame and compares it with the next entry of an expected-frame
// queue. The stimulus fills that queue at every reset release. Each entry's
// content and start cycle come from the message text and the frame and gap
// arithmetic. Resets come at planned and random points. Build with
// +define+UART_PARITY_EN to check the parity variant.
// ============================================================================
module tb_uart_beacon_tx;

    localparam int CPB     = 4;
    localparam int GAP     = 2;
    localparam int MSG_LEN = 11;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int PERIOD_BITS = MSG_LEN * FB + GAP;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic txd;

    uart_beacon_tx #(
        .CLKS_PER_BIT(CPB),
        .GAP_BITS    (GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .TXD(txd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] msg [MSG_LEN] = '{8'h46, 8'h50, 8'h47, 8'h41, 8'h53, 8'h63,
                                  8'h6F, 8'h70, 8'h65, 8'h0D, 8'h0A};

    typedef struct {
        logic [7:0] data;
        int         start;
        int         idx;
    } exp_t;

    exp_t expq[$];

    int checks = 0;
    int passed = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    // Receiver. It triggers on the first low sample and then samples each
    // bit in the middle of its bit-time.
    logic [FB-1:0] frame_bits;
    logic [7:0]    rx_data;
    bit            rx_busy = 1'b0;
    int            rx_start = 0;
    int            rx_bit = 0;
    exp_t          rx_exp;

    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                rx_busy = 1'b0;
            end else begin
                if (!rx_busy && txd === 1'b0) begin
                    rx_busy  = 1'b1;
                    rx_start = cyc;
                    rx_bit   = 0;
                end
                if (rx_busy && cyc == rx_start + rx_bit * CPB + CPB / 2) begin
                    frame_bits[rx_bit] = txd;
                    rx_bit++;
                    if (rx_bit == FB) begin
                        rx_busy = 1'b0;
                        rx_data = frame_bits[8:1];
                        checkOutput("start_bit", int'(frame_bits[0]), 0);
                        checkOutput("stop_bit", int'(frame_bits[FB-1]), 1);
`ifdef UART_PARITY_EN
                        checkOutput($sformatf("parity_0x%02h", rx_data),
                                    int'(frame_bits[9]), $countones(rx_data) % 2);
`endif
                        if (expq.size() == 0) begin
                            checks++;
                            $display("[TB] FAIL unexpected_frame: got byte 0x%02h at cycle %0d, expected no frame",
                                     rx_data, rx_start);
                        end else begin
                            rx_exp = expq.pop_front();
                            checkOutput($sformatf("byte%0d_data", rx_exp.idx),
                                        int'(rx_data), int'(rx_exp.data));
                            checkOutput($sformatf("byte%0d_start_cycle", rx_exp.idx),
                                        rx_start, rx_exp.start);
                        end
                    end
                end
            end
        end
    end

    // Reference timeline. Byte j of message m starts one idle bit-time after
    // release, plus m whole message periods, plus j frames.
    task automatic pushMessages(input int rel, input int nbytes);
        exp_t e;
        for (int k = 0; k < nbytes; k++) begin
            e.idx   = k % MSG_LEN;
            e.data  = msg[e.idx];
            e.start = rel + CPB + ((k / MSG_LEN) * PERIOD_BITS + e.idx * FB) * CPB;
            expq.push_back(e);
        end
    endtask

    // Assert reset now, which is at posedge+2. TXD must go high at once and
    // stay high during the hold. Frames that cannot finish are dropped. Then
    // release reset and queue the frames expected next.
    task automatic applyStimulus(input int hold, input int nbytes, output int rel);
        int bad;
        int overdue;
        overdue = 0;
        if (expq.size() > 0 && expq[0].start + (FB - 1) * CPB + CPB / 2 < cyc)
            overdue = 1;
        checkOutput("no_overdue_frame_at_reset", overdue, 0);
        expq.delete();
        rst = 1'b0;
        #1;
        checkOutput("txd_high_on_reset_assert", int'(txd), 1);
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #2;
            if (txd !== 1'b1) bad++;
        end
        checkOutput($sformatf("txd_low_cycles_in_%0d_cycle_reset", hold), bad, 0);
        rst = 1'b1;
        rel = cyc;
        pushMessages(rel, nbytes);
    endtask

    task automatic waitCycle(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #2;
        end
    endtask

    int rel;
    int target;
    int budget;

    initial begin
        rst = 1'b1;
        @(posedge clk);
        #2;

        // Long reset, then two full messages plus bytes 0..3 of the third.
        // This covers the first frame, back-to-back frames, the gap and the
        // repeat period.
        applyStimulus(25, 2 * MSG_LEN + 4, rel);

        // Reset inside the start bit of byte 4 ('S') of the third message
        target = rel + CPB + (2 * PERIOD_BITS + 4 * FB) * CPB + $urandom_range(1, CPB - 2);
        waitCycle(target);
        checkOutput("txd_low_in_start_bit_before_reset", int'(txd), 0);
        applyStimulus(3, MSG_LEN, rel);

        // Resets at random points within the message
        for (int r = 0; r < 3; r++) begin
            target = rel + CPB + $urandom_range(0, MSG_LEN * FB * CPB - 1);
            waitCycle(target);
            applyStimulus($urandom_range(1, 5), MSG_LEN, rel);
        end

        // Let the last message finish in full, with a cycle bound
        budget = 0;
        while (expq.size() > 0 && budget < (PERIOD_BITS + 4) * CPB + 50) begin
            @(posedge clk);
            #2;
            budget++;
        end
        checkOutput("frames_outstanding_at_end", expq.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
